data_memory_ctrl: RTL
=====================

Name: data_memory_ctrl

Overview:
- Next-generation byte-addressed data memory for the pipeline MEM stage.
- Big-endian: the lowest address holds the MSB.
- Handles byte/half/word/double loads and stores, with sign or zero extension on loads.
- Checks alignment, marks read data with a 1-cycle valid, and has a debug-dump sequencer that streams the whole array to the Debug Unit over a valid/ready handshake.

Parameters:
- MEMORY_WIDTH, 8, bits per storage entry (fixed at 8; any other value is an elaboration error).
- NB_ADDR, 7, byte address width.
- MEMORY_DEPTH, 2**NB_ADDR, number of byte entries.
- NB_DATA, 32, CPU data width; 32 or 64 only; any other value is an elaboration error.

Ports:
- i_clock  in  1  clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  global step enable from the Debug Unit; low freezes all state
- i_mem_write_flag  in  1  CPU store request
- i_mem_read_flag  in  1  CPU load request
- i_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double (double legal only when NB_DATA=64)
- i_unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend
- i_address  in  NB_ADDR  CPU byte address
- i_write_data  in  NB_DATA  store data, right-justified
- o_read_data  out  NB_DATA  load result, extended
- o_read_valid  out  1  load result valid, one-cycle pulse
- o_misaligned  out  1  alignment fault for the access issued last cycle, one-cycle pulse
- i_dump_start  in  1  request a full-array dump
- o_dump_addr  out  NB_ADDR  address of the presented byte
- o_dump_byte  out  8  presented byte
- o_dump_valid  out  1  dump byte valid
- i_dump_ready  in  1  Debug Unit accepts the byte
- o_dump_done  out  1  one-cycle pulse after the last byte is accepted
- o_busy  out  1  dump in progress; CPU accesses are ignored

Behaviour:
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - Array contents are not reset; they are zero-initialised at configuration only.
  - No hard-wired locations.
- i_enable=0: no writes, no FSM transitions, no read launches. Outputs hold, except that o_read_valid, o_misaligned and o_dump_done drop to 0.
- Store: committed at the clock edge when the access is aligned.
  - Byte at A holds bits [8k-1:8k-8] of the size-truncated data, where k = size bytes minus offset.
  - Example: word 0xAABBCCDD at A gives A=AA, A+1=BB, A+2=CC, A+3=DD.
- Load: 1-cycle latency. The result is registered and o_read_valid is high the next cycle.
  - Bits above the access size carry the sign of the MSB, or are 0 when i_unsigned=1.
  - i_unsigned is ignored for a full-width load.
- Alignment: an access is aligned when its address is a multiple of the access size.
  - A misaligned access is suppressed: no write, o_read_valid stays 0, o_misaligned pulses next cycle.
  - Accesses never wrap past MEMORY_DEPTH-1, because an aligned access fits inside the array.
- Illegal size (11 with NB_DATA=32): handled like a misaligned access.
- Read and write flags both high: the write commits, and the read returns the old data (read-before-write).
- Dump FSM states:
  - IDLE: i_dump_start=1 goes to RD with addr=0 and o_busy=1. A CPU access in the same cycle still executes.
  - RD: reads the byte at addr, then goes to PRES.
  - PRES: o_dump_valid=1 while addr and byte are held stable. On i_dump_ready=1, go to DONE if addr==MEMORY_DEPTH-1, else addr+1 and RD.
  - DONE: o_dump_done=1 for one cycle and o_busy=0 next cycle, then IDLE.
- i_dump_start is ignored outside IDLE.
- While o_busy=1, CPU read and write flags are ignored, with no error pulse.
- Reset asserted mid-dump aborts it: state goes to IDLE and no o_dump_done is issued.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: alignment checking exactly as described above.
- Undefined: the low log2(size) address bits are forced to 0, the access always executes, and o_misaligned is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - size codes SIZE_BYTE/HALF/WORD/DOUBLE;
  - dump FSM state encodings DUMP_IDLE/RD/PRES/DONE;
  - the function size_bytes(size).
- One sub-module, dmem_dump_seq: the dump FSM, address counter and handshake. It drives the array read address mux select and o_busy.

Test Plan:
- Store word 0x8899AABB at 0x10, then load word at 0x10 -> next cycle o_read_data=0x8899AABB, o_read_valid=1.
- After that, load byte at 0x10 signed -> 0xFFFFFF88. Load byte unsigned -> 0x00000088. Load half at 0x12 signed -> 0xFFFFAABB.
- Store half at 0x11 with DMEM_MISALIGN_TRAP_EN -> o_misaligned=1 next cycle and memory unchanged. Without the macro, the store writes 0x10/0x11.
- Dump with i_dump_ready toggling every other cycle (DEPTH=128) -> 128 bytes in address order 0..127 matching contents, o_dump_done once, and CPU stores issued during o_busy have no effect.
- Assert i_reset_n low at dump addr 40 -> all outputs 0 and no o_dump_done. A new dump starts from addr 0.
- Hold i_enable=0 with a store pending -> no write, FSM frozen. Restore i_enable -> the operation proceeds.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: access size codes and dump sequencer states.
// No logic, no latency.
// No flow control.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'b00,
    DUMP_RD   = 2'b01,
    DUMP_PRES = 2'b10,
    DUMP_DONE = 2'b11
  } dump_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// CPU access port plus Debug Unit dump stream of the data memory.
// No logic, no latency.
// Dump stream uses valid/ready; the CPU side has no backpressure.
interface data_memory_ctrl_if #(
  parameter int NB_ADDR = 7,
  parameter int NB_DATA = 32
);
  logic               i_enable;
  logic               i_mem_write_flag;
  logic               i_mem_read_flag;
  logic [1:0]         i_size;
  logic               i_unsigned;
  logic [NB_ADDR-1:0] i_address;
  logic [NB_DATA-1:0] i_write_data;
  logic [NB_DATA-1:0] o_read_data;
  logic               o_read_valid;
  logic               o_misaligned;
  logic               i_dump_start;
  logic [NB_ADDR-1:0] o_dump_addr;
  logic [7:0]         o_dump_byte;
  logic               o_dump_valid;
  logic               i_dump_ready;
  logic               o_dump_done;
  logic               o_busy;

  modport master (
    output i_enable, i_mem_write_flag, i_mem_read_flag, i_size, i_unsigned,
           i_address, i_write_data, i_dump_start, i_dump_ready,
    input  o_read_data, o_read_valid, o_misaligned, o_dump_addr, o_dump_byte,
           o_dump_valid, o_dump_done, o_busy
  );

  modport slave (
    input  i_enable, i_mem_write_flag, i_mem_read_flag, i_size, i_unsigned,
           i_address, i_write_data, i_dump_start, i_dump_ready,
    output o_read_data, o_read_valid, o_misaligned, o_dump_addr, o_dump_byte,
           o_dump_valid, o_dump_done, o_busy
  );
endinterface

// File: rtl/dmem_dump_seq.sv
// Dump sequencer: walks every byte address and presents each byte to the Debug Unit.
// One read cycle per byte, then the byte is held until accepted.
// Stalls in PRES while i_dump_ready is low; i_enable low freezes it.
module dmem_dump_seq
  import dmem_pkg::*;
#(
  parameter int NB_ADDR = 7
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  input  logic [7:0]         i_rd_byte,
  output logic               o_rd_sel,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [7:0]         o_dump_byte,
  output logic               o_dump_valid,
  output logic               o_dump_done,
  output logic               o_busy
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  dump_state_e state;

  // The array read port is steered to the dump address only while in RD.
  assign o_rd_sel = (state == DUMP_RD);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= DUMP_IDLE;
      o_dump_addr  <= '0;
      o_dump_byte  <= '0;
      o_dump_valid <= 1'b0;
      o_dump_done  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_dump_done <= 1'b0;
      if (i_enable) begin
        case (state)
          DUMP_IDLE: begin
            if (i_dump_start) begin
              state       <= DUMP_RD;
              o_dump_addr <= '0;
              o_busy      <= 1'b1;
            end
          end
          DUMP_RD: begin
            o_dump_byte  <= i_rd_byte;
            o_dump_valid <= 1'b1;
            state        <= DUMP_PRES;
          end
          DUMP_PRES: begin
            if (i_dump_ready) begin
              o_dump_valid <= 1'b0;
              if (o_dump_addr == LAST_ADDR) begin
                state       <= DUMP_DONE;
                o_dump_done <= 1'b1;
              end else begin
                o_dump_addr <= o_dump_addr + NB_ADDR'(1);
                state       <= DUMP_RD;
              end
            end
          end
          DUMP_DONE: begin
            o_busy <= 1'b0;
            state  <= DUMP_IDLE;
          end
          default: state <= DUMP_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Big-endian byte-addressed data memory with extended loads and a debug dump; DMEM_MISALIGN_TRAP_EN enables alignment faults.
// Loads return one cycle after issue; stores commit at the issuing edge.
// No CPU backpressure (accesses are dropped while o_busy); dump stream stalls on i_dump_ready.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int MEMORY_WIDTH = 8,
  parameter int NB_ADDR      = 7,
  parameter int MEMORY_DEPTH = 2**NB_ADDR,
  parameter int NB_DATA      = 32
) (
  input logic               i_clock,
  input logic               i_reset_n,
  data_memory_ctrl_if.slave bus
);

  localparam int MAX_BYTES = NB_DATA / 8;
  localparam int LANE_W    = $clog2(MAX_BYTES);

  if (MEMORY_WIDTH != 8) begin : g_width_check
    $error("data_memory_ctrl: MEMORY_WIDTH must be 8");
  end
  if (NB_DATA != 32 && NB_DATA != 64) begin : g_data_check
    $error("data_memory_ctrl: NB_DATA must be 32 or 64");
  end

  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [3:0]         nbytes;
  logic               size_legal;
  logic [NB_ADDR-1:0] off_mask;
  logic [NB_ADDR-1:0] eff_addr;
  logic [NB_ADDR-1:0] rd_base;
  logic               exec_ok;
  logic               cpu_req;
  logic               do_read;
  logic               do_write;
  logic               dump_busy;
  logic               dump_sel;
  logic [NB_ADDR-1:0] dump_addr;
  logic [NB_DATA-1:0] ld_raw;
  logic [NB_DATA-1:0] ld_ext;
  logic               ld_msb;
  logic [NB_DATA-1:0] wr_msb;
  logic [7:0]         wbyte [MAX_BYTES];
  logic [NB_DATA-1:0] read_data_q;
  logic               read_valid_q;

  assign nbytes     = size_bytes(bus.i_size);
  assign size_legal = (bus.i_size != SIZE_DOUBLE) || (NB_DATA == 64);
  assign off_mask   = NB_ADDR'(nbytes - 4'd1);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic aligned;
  logic misaligned_q;

  assign aligned  = (bus.i_address & off_mask) == '0;
  assign exec_ok  = size_legal && aligned;
  assign eff_addr = bus.i_address;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) misaligned_q <= 1'b0;
    else            misaligned_q <= cpu_req && !exec_ok;
  end
  assign bus.o_misaligned = misaligned_q;
`else
  // Without the trap the low offset bits are simply dropped.
  assign exec_ok          = size_legal;
  assign eff_addr         = bus.i_address & ~off_mask;
  assign bus.o_misaligned = 1'b0;
`endif

  assign cpu_req  = bus.i_enable && !dump_busy && (bus.i_mem_read_flag || bus.i_mem_write_flag);
  assign do_read  = cpu_req && bus.i_mem_read_flag && exec_ok;
  assign do_write = cpu_req && bus.i_mem_write_flag && exec_ok;
  assign rd_base  = dump_sel ? dump_addr : eff_addr;

  // Load path: lowest address lands in the most significant byte.
  always_comb begin
    ld_raw = '0;
    ld_msb = 1'b0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < int'(nbytes)) ld_raw = {ld_raw[NB_DATA-9:0], mem[rd_base + NB_ADDR'(i)]};
    end
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (k + 1 == int'(nbytes)) ld_msb = ld_raw[8*k+7];
    end
    for (int b = 0; b < NB_DATA; b++) begin
      ld_ext[b] = (b < 8 * int'(nbytes)) ? ld_raw[b] : (ld_msb && !bus.i_unsigned);
    end
  end

  // Store path: left-justify the truncated data so lane 0 is the first byte written.
  always_comb begin
    wr_msb = bus.i_write_data << (8 * (MAX_BYTES - int'(nbytes)));
    for (int i = 0; i < MAX_BYTES; i++) wbyte[i] = wr_msb[NB_DATA-1-8*i -: 8];
  end

  for (genvar j = 0; j < MEMORY_DEPTH; j++) begin : g_mem
    logic [NB_ADDR-1:0] lane;
    assign lane = NB_ADDR'(j) - eff_addr;
    always_ff @(posedge i_clock) begin
      if (do_write && (lane < NB_ADDR'(nbytes))) mem[j] <= wbyte[lane[LANE_W-1:0]];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= do_read;
      if (do_read) read_data_q <= ld_ext;
    end
  end

  assign bus.o_read_data  = read_data_q;
  assign bus.o_read_valid = read_valid_q;
  assign bus.o_dump_addr  = dump_addr;
  assign bus.o_busy       = dump_busy;

  dmem_dump_seq #(.NB_ADDR(NB_ADDR)) u_dump_seq (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_enable     (bus.i_enable),
    .i_dump_start (bus.i_dump_start),
    .i_dump_ready (bus.i_dump_ready),
    .i_rd_byte    (mem[rd_base]),
    .o_rd_sel     (dump_sel),
    .o_dump_addr  (dump_addr),
    .o_dump_byte  (bus.o_dump_byte),
    .o_dump_valid (bus.o_dump_valid),
    .o_dump_done  (bus.o_dump_done),
    .o_busy       (dump_busy)
  );

endmodule
